// File: rtl/sipo_in.sv
// sipo_in: assembles a big-endian 32-bit word from a byte stream and presents
// it as two 16-bit halves with a valid/acknowledge handshake. A second word can
// be collected while the first is still held; finishing it before the held
// word is acknowledged drops it and raises a sticky overrun flag.
module sipo_in (
    input  logic        CLKEXT,
    input  logic        RST_GLO,
    input  logic        EN_SIPO_IN,
    input  logic        CLR_SIPO_IN,
    input  logic        SHIFT_IN,
    input  logic [7:0]  D_IN,
    input  logic        ACK_IN,
    output logic [15:0] mac0_in,
    output logic [15:0] mac1_in,
    output logic        VALID_IN,
    output logic [1:0]  BYTE_CNT,
    output logic        OVR_ERR
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } sipoState_t;

    sipoState_t  r_state;
    sipoState_t  w_nextState;

    logic [31:0] r_shreg;
    logic [1:0]  r_byteCnt;
    logic [15:0] r_mac0;
    logic [15:0] r_mac1;
    logic        r_ovrErr;

    logic        w_accept;
    logic        w_complete;
    logic [31:0] w_word;
    logic        w_loadWord;
    logic        w_overrun;

    assign w_accept   = EN_SIPO_IN & SHIFT_IN;
    assign w_complete = w_accept & (r_byteCnt == 2'd3);
    assign w_word     = {r_shreg[23:0], D_IN};

    // A finished word reaches the outputs when nothing is held or the held
    // word is being acknowledged in the same cycle; otherwise it is an overrun.
    assign w_loadWord = w_complete & ((r_state == FILL) | ACK_IN);
    assign w_overrun  = w_complete & (r_state == HOLD) & ~ACK_IN;

    // State register; clear has priority over any handshake activity.
    always_ff @(posedge CLKEXT or negedge RST_GLO) begin
        if (!RST_GLO) begin
            r_state <= FILL;
        end else if (CLR_SIPO_IN) begin
            r_state <= FILL;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a completed word enters HOLD, a bare acknowledge leaves it.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FILL: begin
                if (w_complete) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (!w_complete && ACK_IN) begin
                    w_nextState = FILL;
                end
            end
            default: w_nextState = FILL;
        endcase
    end

    // Output decode: the word is valid exactly while it is being held.
    always_comb begin
        VALID_IN = 1'b0;
        if (r_state == HOLD) begin
            VALID_IN = 1'b1;
        end
    end

    // Byte collection keeps running in both states so the next word can be
    // gathered while the consumer still owns the presented one.
    always_ff @(posedge CLKEXT or negedge RST_GLO) begin
        if (!RST_GLO) begin
            r_shreg   <= 32'h0;
            r_byteCnt <= 2'd0;
        end else if (CLR_SIPO_IN) begin
            r_shreg   <= 32'h0;
            r_byteCnt <= 2'd0;
        end else if (w_accept) begin
            r_shreg   <= w_word;
            r_byteCnt <= r_byteCnt + 2'd1;
        end
    end

    // Presented word and sticky overrun flag; only clear or reset drop OVR_ERR.
    always_ff @(posedge CLKEXT or negedge RST_GLO) begin
        if (!RST_GLO) begin
            r_mac0   <= 16'h0;
            r_mac1   <= 16'h0;
            r_ovrErr <= 1'b0;
        end else if (CLR_SIPO_IN) begin
            r_mac0   <= 16'h0;
            r_mac1   <= 16'h0;
            r_ovrErr <= 1'b0;
        end else begin
            if (w_loadWord) begin
                r_mac0 <= w_word[31:16];
                r_mac1 <= w_word[15:0];
            end
            if (w_overrun) begin
                r_ovrErr <= 1'b1;
            end
        end
    end

    assign mac0_in  = r_mac0;
    assign mac1_in  = r_mac1;
    assign BYTE_CNT = r_byteCnt;
    assign OVR_ERR  = r_ovrErr;

endmodule

// File: tb/tb_sipo_in.sv
// tb_sipo_in: directed scenarios for the byte-to-word assembler, each task
// driving its own vectors and checking hand-computed results.
module tb_sipo_in;

    logic        CLKEXT;
    logic        RST_GLO;
    logic        EN_SIPO_IN;
    logic        CLR_SIPO_IN;
    logic        SHIFT_IN;
    logic [7:0]  D_IN;
    logic        ACK_IN;
    logic [15:0] mac0_in;
    logic [15:0] mac1_in;
    logic        VALID_IN;
    logic [1:0]  BYTE_CNT;
    logic        OVR_ERR;

    int checks;
    int failures;

    sipo_in dut (
        .CLKEXT      (CLKEXT),
        .RST_GLO     (RST_GLO),
        .EN_SIPO_IN  (EN_SIPO_IN),
        .CLR_SIPO_IN (CLR_SIPO_IN),
        .SHIFT_IN    (SHIFT_IN),
        .D_IN        (D_IN),
        .ACK_IN      (ACK_IN),
        .mac0_in     (mac0_in),
        .mac1_in     (mac1_in),
        .VALID_IN    (VALID_IN),
        .BYTE_CNT    (BYTE_CNT),
        .OVR_ERR     (OVR_ERR)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        CLKEXT = 1'b0;
        forever #5 CLKEXT = ~CLKEXT;
    end

    // Advance one rising edge and settle 1 unit after it.
    task automatic cycle();
        @(posedge CLKEXT);
        #1;
    endtask

    // Present one byte for a single edge, optionally with acknowledge.
    task automatic sendByte(input logic [7:0] d, input logic ack);
        EN_SIPO_IN = 1'b1;
        SHIFT_IN   = 1'b1;
        D_IN       = d;
        ACK_IN     = ack;
        cycle();
        EN_SIPO_IN = 1'b0;
        SHIFT_IN   = 1'b0;
        ACK_IN     = 1'b0;
    endtask

    task automatic test_reset();
        RST_GLO     = 1'b0;
        EN_SIPO_IN  = 1'b0;
        CLR_SIPO_IN = 1'b0;
        SHIFT_IN    = 1'b0;
        D_IN        = 8'h00;
        ACK_IN      = 1'b0;
        #2;
        checks++; if (mac0_in !== 16'h0000) begin failures++; $display("FAIL reset_mac0 got %h exp 0000", mac0_in); end
        checks++; if (mac1_in !== 16'h0000) begin failures++; $display("FAIL reset_mac1 got %h exp 0000", mac1_in); end
        checks++; if (VALID_IN !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", VALID_IN); end
        checks++; if (BYTE_CNT !== 2'd0) begin failures++; $display("FAIL reset_cnt got %0d exp 0", BYTE_CNT); end
        checks++; if (OVR_ERR !== 1'b0) begin failures++; $display("FAIL reset_ovr got %b exp 0", OVR_ERR); end
        cycle();
        cycle();
        RST_GLO = 1'b1;
        cycle();
    endtask

    task automatic test_basic_word();
        sendByte(8'hAA, 1'b0);
        checks++; if (BYTE_CNT !== 2'd1) begin failures++; $display("FAIL basic_cnt1 got %0d exp 1", BYTE_CNT); end
        checks++; if (VALID_IN !== 1'b0) begin failures++; $display("FAIL basic_valid_early got %b exp 0", VALID_IN); end
        sendByte(8'hAA, 1'b0);
        sendByte(8'h55, 1'b0);
        checks++; if (BYTE_CNT !== 2'd3) begin failures++; $display("FAIL basic_cnt3 got %0d exp 3", BYTE_CNT); end
        sendByte(8'h55, 1'b0);
        checks++; if (mac0_in !== 16'hAAAA) begin failures++; $display("FAIL basic_mac0 got %h exp AAAA", mac0_in); end
        checks++; if (mac1_in !== 16'h5555) begin failures++; $display("FAIL basic_mac1 got %h exp 5555", mac1_in); end
        checks++; if (VALID_IN !== 1'b1) begin failures++; $display("FAIL basic_valid got %b exp 1", VALID_IN); end
        checks++; if (BYTE_CNT !== 2'd0) begin failures++; $display("FAIL basic_cnt_wrap got %0d exp 0", BYTE_CNT); end
        ACK_IN = 1'b1;
        cycle();
        ACK_IN = 1'b0;
        checks++; if (VALID_IN !== 1'b0) begin failures++; $display("FAIL basic_ack_valid got %b exp 0", VALID_IN); end
        checks++; if (mac0_in !== 16'hAAAA) begin failures++; $display("FAIL basic_ack_mac0 got %h exp AAAA", mac0_in); end
        checks++; if (mac1_in !== 16'h5555) begin failures++; $display("FAIL basic_ack_mac1 got %h exp 5555", mac1_in); end
        ACK_IN = 1'b1;
        cycle();
        ACK_IN = 1'b0;
        checks++; if (VALID_IN !== 1'b0) begin failures++; $display("FAIL fill_ack_valid got %b exp 0", VALID_IN); end
        checks++; if (mac0_in !== 16'hAAAA) begin failures++; $display("FAIL fill_ack_mac0 got %h exp AAAA", mac0_in); end
    endtask

    task automatic test_enable_gap();
        sendByte(8'h12, 1'b0);
        sendByte(8'h34, 1'b0);
        for (int i = 0; i < 3; i++) begin
            EN_SIPO_IN = 1'b0;
            SHIFT_IN   = 1'b1;
            D_IN       = (i % 2 == 0) ? 8'hF0 : 8'h0F;
            cycle();
            checks++; if (BYTE_CNT !== 2'd2) begin failures++; $display("FAIL gap_cnt%0d got %0d exp 2", i, BYTE_CNT); end
        end
        SHIFT_IN = 1'b0;
        sendByte(8'hAB, 1'b0);
        sendByte(8'hCD, 1'b0);
        checks++; if (mac0_in !== 16'h1234) begin failures++; $display("FAIL gap_mac0 got %h exp 1234", mac0_in); end
        checks++; if (mac1_in !== 16'hABCD) begin failures++; $display("FAIL gap_mac1 got %h exp ABCD", mac1_in); end
        checks++; if (VALID_IN !== 1'b1) begin failures++; $display("FAIL gap_valid got %b exp 1", VALID_IN); end
        ACK_IN = 1'b1;
        cycle();
        ACK_IN = 1'b0;
    endtask

    task automatic test_overrun();
        sendByte(8'hFF, 1'b0);
        sendByte(8'hFF, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'h00, 1'b0);
        checks++; if (VALID_IN !== 1'b1) begin failures++; $display("FAIL ovr_first_valid got %b exp 1", VALID_IN); end
        checks++; if (OVR_ERR !== 1'b0) begin failures++; $display("FAIL ovr_first_flag got %b exp 0", OVR_ERR); end
        sendByte(8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        sendByte(8'h33, 1'b0);
        checks++; if (mac0_in !== 16'hFFFF) begin failures++; $display("FAIL ovr_hold_stable got %h exp FFFF", mac0_in); end
        sendByte(8'h44, 1'b0);
        checks++; if (OVR_ERR !== 1'b1) begin failures++; $display("FAIL ovr_flag got %b exp 1", OVR_ERR); end
        checks++; if (mac0_in !== 16'hFFFF) begin failures++; $display("FAIL ovr_mac0 got %h exp FFFF", mac0_in); end
        checks++; if (mac1_in !== 16'h0000) begin failures++; $display("FAIL ovr_mac1 got %h exp 0000", mac1_in); end
        checks++; if (VALID_IN !== 1'b1) begin failures++; $display("FAIL ovr_valid got %b exp 1", VALID_IN); end
        sendByte(8'h11, 1'b0);
        sendByte(8'h22, 1'b0);
        sendByte(8'h33, 1'b0);
        sendByte(8'h44, 1'b1);
        checks++; if (mac0_in !== 16'h1122) begin failures++; $display("FAIL b2b_mac0 got %h exp 1122", mac0_in); end
        checks++; if (mac1_in !== 16'h3344) begin failures++; $display("FAIL b2b_mac1 got %h exp 3344", mac1_in); end
        checks++; if (VALID_IN !== 1'b1) begin failures++; $display("FAIL b2b_valid got %b exp 1", VALID_IN); end
        checks++; if (OVR_ERR !== 1'b1) begin failures++; $display("FAIL b2b_ovr got %b exp 1", OVR_ERR); end
        EN_SIPO_IN = 1'b0;
        ACK_IN     = 1'b1;
        cycle();
        ACK_IN = 1'b0;
        checks++; if (VALID_IN !== 1'b0) begin failures++; $display("FAIL ack_noen_valid got %b exp 0", VALID_IN); end
        checks++; if (OVR_ERR !== 1'b1) begin failures++; $display("FAIL ovr_sticky got %b exp 1", OVR_ERR); end
        checks++; if (mac0_in !== 16'h1122) begin failures++; $display("FAIL ack_noen_mac0 got %h exp 1122", mac0_in); end
    endtask

    task automatic test_clear();
        sendByte(8'hDE, 1'b0);
        sendByte(8'hAD, 1'b0);
        CLR_SIPO_IN = 1'b1;
        EN_SIPO_IN  = 1'b1;
        SHIFT_IN    = 1'b1;
        D_IN        = 8'hBE;
        ACK_IN      = 1'b1;
        cycle();
        CLR_SIPO_IN = 1'b0;
        EN_SIPO_IN  = 1'b0;
        SHIFT_IN    = 1'b0;
        ACK_IN      = 1'b0;
        checks++; if (mac0_in !== 16'h0000) begin failures++; $display("FAIL clr_mac0 got %h exp 0000", mac0_in); end
        checks++; if (mac1_in !== 16'h0000) begin failures++; $display("FAIL clr_mac1 got %h exp 0000", mac1_in); end
        checks++; if (VALID_IN !== 1'b0) begin failures++; $display("FAIL clr_valid got %b exp 0", VALID_IN); end
        checks++; if (BYTE_CNT !== 2'd0) begin failures++; $display("FAIL clr_cnt got %0d exp 0", BYTE_CNT); end
        checks++; if (OVR_ERR !== 1'b0) begin failures++; $display("FAIL clr_ovr got %b exp 0", OVR_ERR); end
        sendByte(8'h01, 1'b0);
        sendByte(8'h02, 1'b0);
        sendByte(8'h03, 1'b0);
        sendByte(8'h04, 1'b0);
        checks++; if (mac0_in !== 16'h0102) begin failures++; $display("FAIL clr_next_mac0 got %h exp 0102", mac0_in); end
        checks++; if (mac1_in !== 16'h0304) begin failures++; $display("FAIL clr_next_mac1 got %h exp 0304", mac1_in); end
        checks++; if (VALID_IN !== 1'b1) begin failures++; $display("FAIL clr_next_valid got %b exp 1", VALID_IN); end
    endtask

    task automatic test_async_reset();
        ACK_IN = 1'b1;
        cycle();
        ACK_IN = 1'b0;
        sendByte(8'h77, 1'b0);
        sendByte(8'h88, 1'b0);
        sendByte(8'h99, 1'b0);
        #2;
        RST_GLO = 1'b0;
        #1;
        checks++; if (mac0_in !== 16'h0000) begin failures++; $display("FAIL arst_mac0 got %h exp 0000", mac0_in); end
        checks++; if (mac1_in !== 16'h0000) begin failures++; $display("FAIL arst_mac1 got %h exp 0000", mac1_in); end
        checks++; if (BYTE_CNT !== 2'd0) begin failures++; $display("FAIL arst_cnt got %0d exp 0", BYTE_CNT); end
        checks++; if (VALID_IN !== 1'b0) begin failures++; $display("FAIL arst_valid got %b exp 0", VALID_IN); end
        #2;
        RST_GLO = 1'b1;
        cycle();
        sendByte(8'h5A, 1'b0);
        sendByte(8'hA5, 1'b0);
        sendByte(8'hC3, 1'b0);
        checks++; if (VALID_IN !== 1'b0) begin failures++; $display("FAIL arst_partial_valid got %b exp 0", VALID_IN); end
        sendByte(8'h3C, 1'b0);
        checks++; if (mac0_in !== 16'h5AA5) begin failures++; $display("FAIL arst_next_mac0 got %h exp 5AA5", mac0_in); end
        checks++; if (mac1_in !== 16'hC33C) begin failures++; $display("FAIL arst_next_mac1 got %h exp C33C", mac1_in); end
        checks++; if (BYTE_CNT !== 2'd0) begin failures++; $display("FAIL arst_next_cnt got %0d exp 0", BYTE_CNT); end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_word();
        test_enable_gap();
        test_overrun();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
